regfile_read_mux: RTL and testbench



---
 rtl/regfile_read_mux.sv | 60 ++++++
 tb/tb_regfile_read_mux.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_mux.sv
// Registered multi-port register-file read select with writeback forwarding and hardwired zero entry.
// One cycle latency; stall freezes every output register and discards that cycle's requests.
module regfile_read_mux #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int PORTS    = 2,
   parameter bit ZERO_EN  = 1'b1,
   parameter int ZERO_IDX = DEPTH - 1,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DEPTH*WIDTH-1:0]  data,
   input  logic [PORTS-1:0]        rd_valid,
   input  logic [PORTS*ADDR_W-1:0] rd_addr,
   input  logic                    fwd_en,
   input  logic [ADDR_W-1:0]       fwd_addr,
   input  logic [WIDTH-1:0]        fwd_data,
   input  logic                    stall,
   output logic [PORTS-1:0]        out_valid,
   output logic [PORTS*WIDTH-1:0]  out_data
);

   for (genvar p = 0; p < PORTS; p++) begin : g_port
      logic [ADDR_W-1:0] addr;
      logic              is_zero;
      logic              is_fwd;
      logic [WIDTH-1:0]  sel;
      logic              vld_q;
      logic [WIDTH-1:0]  dat_q;

      assign addr    = rd_addr[p*ADDR_W +: ADDR_W];
      assign is_zero = ZERO_EN && (addr == ADDR_W'(ZERO_IDX));
      assign is_fwd  = fwd_en && (fwd_addr == addr);

      // Zero register outranks forwarding, so a write to it can never leak out.
      always_comb begin
         sel = data[addr*WIDTH +: WIDTH];
         if (is_zero)
            sel = '0;
         else if (is_fwd)
            sel = fwd_data;
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            vld_q <= 1'b0;
            dat_q <= '0;
         end else if (!stall) begin
            vld_q <= rd_valid[p];
            if (rd_valid[p])
               dat_q <= sel;
         end
      end

      assign out_valid[p]                 = vld_q;
      assign out_data[p*WIDTH +: WIDTH]   = dat_q;
   end

endmodule

// File: tb/tb_regfile_read_mux.sv
// Bench for regfile_read_mux: default configuration plus a WIDTH=8/DEPTH=4/PORTS=3/ZERO_EN=0 instance.
module tb_regfile_read_mux;
   localparam int W = 64, D = 32, P = 2, AW = 5;
   localparam int SW = 8, SD = 4, SP = 3, SAW = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [D*W-1:0]   data;
   logic [P-1:0]     rd_valid;
   logic [P*AW-1:0]  rd_addr;
   logic             fwd_en;
   logic [AW-1:0]    fwd_addr;
   logic [W-1:0]     fwd_data;
   logic             stall;
   logic [P-1:0]     out_valid;
   logic [P*W-1:0]   out_data;

   logic [SD*SW-1:0]  s_data;
   logic [SP-1:0]     s_rd_valid;
   logic [SP*SAW-1:0] s_rd_addr;
   logic              s_fwd_en;
   logic [SAW-1:0]    s_fwd_addr;
   logic [SW-1:0]     s_fwd_data;
   logic              s_stall;
   logic [SP-1:0]     s_out_valid;
   logic [SP*SW-1:0]  s_out_data;

   regfile_read_mux dut (
      .clk(clk), .reset(reset), .data(data), .rd_valid(rd_valid), .rd_addr(rd_addr),
      .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .stall(stall),
      .out_valid(out_valid), .out_data(out_data));

   regfile_read_mux #(.WIDTH(SW), .DEPTH(SD), .PORTS(SP), .ZERO_EN(1'b0)) dut_s (
      .clk(clk), .reset(reset), .data(s_data), .rd_valid(s_rd_valid), .rd_addr(s_rd_addr),
      .fwd_en(s_fwd_en), .fwd_addr(s_fwd_addr), .fwd_data(s_fwd_data), .stall(s_stall),
      .out_valid(s_out_valid), .out_data(s_out_data));

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Reference read rule: zero register first, then same-cycle bypass, then the stored entry.
   function automatic logic [63:0] ref_sel(input bit zero_en, input int zero_idx, input int a,
                                           input bit fen, input int fa, input logic [63:0] fd,
                                           input logic [63:0] ent);
      if (zero_en && a == zero_idx) return 64'h0;
      if (fen && fa == a) return fd;
      return ent;
   endfunction

   typedef struct {
      logic [4:0]  a0, a1;
      logic [1:0]  v;
      logic        fen;
      logic [4:0]  fa;
      logic [63:0] fd;
      logic        st;
      logic [1:0]  ev;
      logic [63:0] e0, e1;
   } vec_t;
   vec_t vecs[14];

   logic [W-1:0]  m_ent[D];
   logic [SW-1:0] s_ent[SD];
   logic [P-1:0]  m_ov;
   logic [W-1:0]  m_od[P];
   logic [SP-1:0] s_ov;
   logic [SW-1:0] s_od[SP];

   initial begin
      vecs[0]  = '{5'd5,  5'd30, 2'b11, 1'b0, 5'd0,  64'h0,    1'b0, 2'b11, 64'h1005, 64'h101E};
      vecs[1]  = '{5'd5,  5'd31, 2'b11, 1'b1, 5'd5,  64'hDEAD, 1'b0, 2'b11, 64'hDEAD, 64'h0};
      vecs[2]  = '{5'd5,  5'd31, 2'b11, 1'b1, 5'd31, 64'hBEEF, 1'b0, 2'b11, 64'h1005, 64'h0};
      vecs[3]  = '{5'd3,  5'd30, 2'b11, 1'b0, 5'd0,  64'h0,    1'b0, 2'b11, 64'h1003, 64'h101E};
      vecs[4]  = '{5'd7,  5'd30, 2'b11, 1'b0, 5'd0,  64'h0,    1'b1, 2'b11, 64'h1003, 64'h101E};
      vecs[5]  = '{5'd7,  5'd30, 2'b11, 1'b0, 5'd0,  64'h0,    1'b1, 2'b11, 64'h1003, 64'h101E};
      vecs[6]  = '{5'd7,  5'd30, 2'b11, 1'b0, 5'd0,  64'h0,    1'b1, 2'b11, 64'h1003, 64'h101E};
      vecs[7]  = '{5'd7,  5'd30, 2'b11, 1'b0, 5'd0,  64'h0,    1'b0, 2'b11, 64'h1007, 64'h101E};
      vecs[8]  = '{5'd4,  5'd2,  2'b11, 1'b0, 5'd0,  64'h0,    1'b0, 2'b11, 64'h1004, 64'h1002};
      vecs[9]  = '{5'd9,  5'd6,  2'b10, 1'b0, 5'd0,  64'h0,    1'b0, 2'b10, 64'h1004, 64'h1006};
      vecs[10] = '{5'd9,  5'd6,  2'b00, 1'b0, 5'd0,  64'h0,    1'b0, 2'b00, 64'h1004, 64'h1006};
      vecs[11] = '{5'd2,  5'd2,  2'b11, 1'b1, 5'd2,  64'hCAFE, 1'b0, 2'b11, 64'hCAFE, 64'hCAFE};
      vecs[12] = '{5'd9,  5'd9,  2'b11, 1'b1, 5'd9,  64'hF00D, 1'b1, 2'b11, 64'hCAFE, 64'hCAFE};
      vecs[13] = '{5'd9,  5'd9,  2'b11, 1'b0, 5'd0,  64'h0,    1'b0, 2'b11, 64'h1009, 64'h1009};

      reset = 1'b1;
      for (int i = 0; i < D; i++) data[i*W +: W] = 64'h1000 + 64'(i);
      for (int i = 0; i < SD; i++) s_data[i*SW +: SW] = 8'h10 + 8'(i);
      rd_valid = '0; rd_addr = '0; fwd_en = 1'b0; fwd_addr = '0; fwd_data = '0; stall = 1'b0;
      s_rd_valid = '0; s_rd_addr = '0; s_fwd_en = 1'b0; s_fwd_addr = '0; s_fwd_data = '0; s_stall = 1'b0;

      #2;
      check("reset_valid", 64'(out_valid), 64'h0);
      check("reset_data", 64'(out_data), 64'h0);
      rd_valid = 2'b11;
      rd_addr  = {5'd30, 5'd5};
      step;
      check("reset_held_valid", 64'(out_valid), 64'h0);
      check("reset_held_data", 64'(out_data), 64'h0);
      check("reset_held_s_valid", 64'(s_out_valid), 64'h0);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         rd_addr  = {vecs[i].a1, vecs[i].a0};
         rd_valid = vecs[i].v;
         fwd_en   = vecs[i].fen;
         fwd_addr = vecs[i].fa;
         fwd_data = vecs[i].fd;
         stall    = vecs[i].st;
         step;
         check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
         check($sformatf("vec%0d_data0", i), out_data[0 +: W], vecs[i].e0);
         check($sformatf("vec%0d_data1", i), out_data[W +: W], vecs[i].e1);
      end

      // Asynchronous reset landing mid-cycle while stalled.
      fwd_en = 1'b0;
      stall  = 1'b1;
      #3 reset = 1'b1;
      #1;
      check("async_reset_valid", 64'(out_valid), 64'h0);
      check("async_reset_data", 64'(out_data), 64'h0);
      step;
      check("reset_stall_valid", 64'(out_valid), 64'h0);
      reset = 1'b0;
      stall = 1'b0;
      rd_addr = {5'd30, 5'd5};
      s_data[3*SW +: SW] = 8'hA5;
      s_rd_addr  = {2'd3, 2'd3, 2'd3};
      s_rd_valid = 3'b111;
      step;
      check("post_reset_valid", 64'(out_valid), 64'h3);
      check("post_reset_data0", out_data[0 +: W], 64'h1005);
      check("post_reset_data1", out_data[W +: W], 64'h101E);
      check("sweep_addr3_valid", 64'(s_out_valid), 64'h7);
      for (int p = 0; p < SP; p++)
         check($sformatf("sweep_addr3_p%0d", p), 64'(s_out_data[p*SW +: SW]), 64'hA5);

      m_ov = 2'b11; m_od[0] = 64'h1005; m_od[1] = 64'h101E;
      s_ov = 3'b111;
      for (int p = 0; p < SP; p++) s_od[p] = 8'hA5;

      for (int n = 0; n < 1000; n++) begin
         for (int i = 0; i < D; i++) begin
            m_ent[i] = {$urandom, $urandom};
            data[i*W +: W] = m_ent[i];
         end
         for (int i = 0; i < SD; i++) begin
            s_ent[i] = 8'($urandom);
            s_data[i*SW +: SW] = s_ent[i];
         end
         rd_valid = 2'($urandom);
         rd_addr  = 10'($urandom);
         fwd_en   = 1'($urandom);
         fwd_addr = ($urandom_range(0, 1) == 1) ? rd_addr[0 +: AW] : 5'($urandom);
         fwd_data = {$urandom, $urandom};
         stall    = ($urandom_range(0, 3) == 0);
         s_rd_valid = 3'($urandom);
         s_rd_addr  = 6'($urandom);
         s_fwd_en   = 1'($urandom);
         s_fwd_addr = 2'($urandom);
         s_fwd_data = 8'($urandom);
         s_stall    = ($urandom_range(0, 3) == 0);

         if (!stall)
            for (int p = 0; p < P; p++) begin
               m_ov[p] = rd_valid[p];
               if (rd_valid[p])
                  m_od[p] = ref_sel(1'b1, D - 1, int'(rd_addr[p*AW +: AW]), fwd_en, int'(fwd_addr),
                                    fwd_data, m_ent[rd_addr[p*AW +: AW]]);
            end
         if (!s_stall)
            for (int p = 0; p < SP; p++) begin
               s_ov[p] = s_rd_valid[p];
               if (s_rd_valid[p])
                  s_od[p] = SW'(ref_sel(1'b0, SD - 1, int'(s_rd_addr[p*SAW +: SAW]), s_fwd_en,
                                        int'(s_fwd_addr), 64'(s_fwd_data),
                                        64'(s_ent[s_rd_addr[p*SAW +: SAW]])));
            end

         step;
         for (int p = 0; p < P; p++) begin
            check($sformatf("rnd%0d_p%0d_valid", n, p), 64'(out_valid[p]), 64'(m_ov[p]));
            check($sformatf("rnd%0d_p%0d_data", n, p), out_data[p*W +: W], m_od[p]);
         end
         for (int p = 0; p < SP; p++) begin
            check($sformatf("sweep%0d_p%0d_valid", n, p), 64'(s_out_valid[p]), 64'(s_ov[p]));
            check($sformatf("sweep%0d_p%0d_data", n, p), 64'(s_out_data[p*SW +: SW]), 64'(s_od[p]));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
